// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, none/odd/even parity, 1-2 stop bits,
// 3-sample majority vote per bit, with parity/framing/break status per word.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 23,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1   = CW'(HALF);
  localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
  } state_e;

  state_e               state_q;
  logic                 sync_q, rx_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic                 s0_q, s1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_acc_q, ones_q, stop0_q, ferr_q;

  logic          maj_d, dec_d, first_stop_d, ferr_d, brk_d, perr_d, last_stop_d;
  logic [CW-1:0] cnt_d;

  always_comb begin
    maj_d        = (s0_q & s1_q) | (s0_q & rx_q) | (s1_q & rx_q);
    dec_d        = (cnt_q == C_DEC);
    cnt_d        = (cnt_q == C_LAST) ? '0 : cnt_q + C_ONE;
    // Break looks only at the first stop bit, even when two are configured.
    first_stop_d = (bit_q == 4'd0) ? maj_d : stop0_q;
    ferr_d       = ferr_q | ~maj_d;
    brk_d        = ~ones_q & ~first_stop_d;
    perr_d       = (PARITY == 1) ? ~par_acc_q : ((PARITY == 2) ? par_acc_q : 1'b0);
    last_stop_d  = (bit_q == 4'(STOP_BITS - 1));
  end

  assign o_Busy = (state_q != S_IDLE);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync_q       <= 1'b1;
      rx_q         <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      ones_q       <= 1'b0;
      stop0_q      <= 1'b0;
      ferr_q       <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      sync_q  <= i_Rx_Serial;
      rx_q    <= sync_q;
      o_Rx_DV <= 1'b0;
      if (cnt_q == C_S0) s0_q <= rx_q;
      if (cnt_q == C_S1) s1_q <= rx_q;

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          // The detection cycle itself counts as c = 0 of the start bit.
          if (!rx_q) begin
            cnt_q     <= C_ONE;
            state_q   <= S_START;
            par_acc_q <= 1'b0;
            ones_q    <= 1'b0;
            ferr_q    <= 1'b0;
            stop0_q   <= 1'b1;
          end
        end
        S_START: begin
          cnt_q <= cnt_d;
          if (dec_d) begin
            if (maj_d) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          if (dec_d) begin
            shift_q   <= {maj_d, shift_q[DATA_BITS-1:1]};
            par_acc_q <= par_acc_q ^ maj_d;
            ones_q    <= ones_q | maj_d;
            if (bit_q == 4'(DATA_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        S_PAR: begin
          cnt_q <= cnt_d;
          if (dec_d) begin
            par_acc_q <= par_acc_q ^ maj_d;
            ones_q    <= ones_q | maj_d;
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          cnt_q <= cnt_d;
          if (dec_d) begin
            ferr_q <= ferr_d;
            if (bit_q == 4'd0) stop0_q <= maj_d;
            if (last_stop_d) begin
              o_Rx_DV      <= 1'b1;
              o_Rx_Byte    <= shift_q;
              o_Parity_Err <= perr_d;
              o_Frame_Err  <= ferr_d;
              o_Break      <= brk_d;
              cnt_q        <= '0;
              bit_q        <= '0;
              // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
              state_q      <= ferr_d ? S_WAIT_HIGH : S_IDLE;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        S_WAIT_HIGH: begin
          cnt_q <= '0;
          if (rx_q) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

endmodule
